gray_to_bin_pipe: RTL and testbench

- Pipelined Gray-to-binary decoder. It is the inverse of the team's combinational binary-to-Gray block, which uses the same 3-bit enable code.
- Accepts Gray words over a valid/ready handshake and resolves binary bits MSB-first across STAGES register stages.
- Presents binary words downstream over a valid/ready handshake, with full back-pressure support.
- Used on the receive side of clock-domain-crossing pointer paths and position-encoder interfaces.

---
 rtl/gray_pkg.sv | 39 +++
 rtl/gray_to_bin_stage.sv | 41 ++++
 rtl/gray_to_bin_pipe.sv | 73 +++++++
 tb/tb_gray_to_bin_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: enable code, pipeline chunk partitioning and a
// combinational reference decoder.
package gray_pkg;

    localparam logic [2:0] EN_CODE = 3'b100;

    typedef struct packed {
        int   hi;
        int   lo;
        logic empty;
    } chunk_t;

    // Bit range resolved by stage k; an empty range reports hi = lo = 0.
    function automatic chunk_t chunk_bounds(input int width, input int stages, input int k);
        chunk_t r;
        int     c;
        c       = (width + stages - 1) / stages;
        r.hi    = width - 1 - k * c;
        r.lo    = width - (k + 1) * c;
        if (r.lo < 0) r.lo = 0;
        r.empty = (r.hi < 0);
        if (r.empty) begin
            r.hi = 0;
            r.lo = 0;
        end
        return r;
    endfunction

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic logic [63:0] gray_to_bin(input logic [63:0] g, input int unsigned width);
        logic [63:0] gm;
        logic [63:0] b;
        gm = g & ~({64{1'b1}} << width);
        b  = gm;
        for (int unsigned s = 1; s < width; s++) b = b ^ (gm >> s);
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin_stage.sv
// One pipeline stage: valid flag plus a word whose upper bits are already
// binary and whose lower bits are still Gray; resolves NBITS bits below HI+1.
module gray_to_bin_stage #(
    parameter int WIDTH = 8,
    parameter int HI    = 7,
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] resolved;

    // The extra zero bit on top makes the MSB carry-in uniform with the others.
    always_comb begin
        ext = {1'b0, up_data};
        for (int unsigned j = 0; j < NBITS; j++) begin
            ext[HI - j] = ext[HI - j] ^ ext[HI - j + 1];
        end
        resolved = ext[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= resolved;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gray_to_bin_pipe.sv
// Pipelined Gray-to-binary decoder with valid/ready handshakes on both sides;
// latency STAGES cycles, one word per cycle, full back-pressure.
module gray_to_bin_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       en_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    import gray_pkg::*;

    logic             en_ok;
    logic [STAGES-1:0] stage_vld;
    logic [STAGES:0]   stage_rdy;
    logic [WIDTH-1:0]  stage_data [STAGES];
    logic              acc;

    assign en_ok   = (en_i == EN_CODE);
    assign ready_o = !rst_i && en_ok && stage_rdy[0];
    assign valid_o = stage_vld[STAGES-1];
    assign data_o  = stage_data[STAGES-1];

    // Stage k can take a word if any stage from k onward is empty or the sink
    // is ready; flattened from the recursive form to keep one evaluation pass.
    always_comb begin
        stage_rdy         = '0;
        acc               = 1'b0;
        stage_rdy[STAGES] = ready_i;
        for (int unsigned k = 0; k < STAGES; k++) begin
            acc = ready_i;
            for (int unsigned j = k; j < STAGES; j++) acc = acc || !stage_vld[j];
            stage_rdy[k] = acc;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam chunk_t BND = chunk_bounds(WIDTH, STAGES, k);

        logic             load;
        logic [WIDTH-1:0] up_data;

        if (k == 0) begin : g_first
            assign load    = valid_i && ready_o;
            assign up_data = data_i;
        end else begin : g_next
            assign load    = stage_vld[k-1] && stage_rdy[k];
            assign up_data = stage_data[k-1];
        end

        gray_to_bin_stage #(
            .WIDTH (WIDTH),
            .HI    (BND.hi),
            .NBITS (BND.empty ? 0 : BND.hi - BND.lo + 1)
        ) u_stage (
            .clk     (clk_i),
            .rst     (rst_i),
            .load    (load),
            .drain   (stage_rdy[k+1]),
            .up_data (up_data),
            .valid   (stage_vld[k]),
            .data    (stage_data[k])
        );
    end

endmodule

// File: tb/tb_gray_to_bin_pipe.sv
// Directed self-checking bench for gray_to_bin_pipe: decode vectors, back-pressure,
// enable gating, async reset, and round trips at STAGES = 1, 3 and 8.
module tb_gray_to_bin_pipe;

    import gray_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] en;
    logic       vin;
    logic       rdy_out;
    logic [7:0] din;
    logic       vout;
    logic       rdy_in;
    logic [7:0] dout;

    logic       rt_valid;
    logic [7:0] rt_data;
    logic [2:0] rt_en;
    logic       rt_ready;
    logic       rt_ro [3];
    logic       rt_vo [3];
    logic [7:0] rt_do [3];

    int n_checks = 0;
    int n_fail   = 0;

    gray_to_bin_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .valid_i(vin), .ready_o(rdy_out),
        .data_i(din), .valid_o(vout), .ready_i(rdy_in), .data_o(dout)
    );

    gray_to_bin_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clk_i(clk), .rst_i(rst), .en_i(rt_en), .valid_i(rt_valid), .ready_o(rt_ro[0]),
        .data_i(rt_data), .valid_o(rt_vo[0]), .ready_i(rt_ready), .data_o(rt_do[0])
    );

    gray_to_bin_pipe #(.WIDTH(8), .STAGES(3)) dut_s3 (
        .clk_i(clk), .rst_i(rst), .en_i(rt_en), .valid_i(rt_valid), .ready_o(rt_ro[1]),
        .data_i(rt_data), .valid_o(rt_vo[1]), .ready_i(rt_ready), .data_o(rt_do[1])
    );

    gray_to_bin_pipe #(.WIDTH(8), .STAGES(8)) dut_s8 (
        .clk_i(clk), .rst_i(rst), .en_i(rt_en), .valid_i(rt_valid), .ready_o(rt_ro[2]),
        .data_i(rt_data), .valid_o(rt_vo[2]), .ready_i(rt_ready), .data_o(rt_do[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] g_basic [4] = '{8'h00, 8'h03, 8'hC0, 8'h80};
    logic [7:0] b_basic [4] = '{8'h00, 8'h02, 8'h80, 8'hFF};
    logic [7:0] g_bp    [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [7:0] b_bp    [6] = '{8'h01, 8'h03, 8'h02, 8'h07, 8'h06, 8'h04};
    int         rt_stages [3] = '{1, 3, 8};

    initial begin
        int         idx_in;
        int         idx_out;
        logic       stalled_prev;
        logic [7:0] last_d;
        logic       fire_in;
        logic       fire_out;
        logic       exp_v;
        int         s;

        rst      = 1'b1;
        en       = 3'b100;
        vin      = 1'b1;
        din      = 8'h00;
        rdy_in   = 1'b1;
        rt_en    = 3'b100;
        rt_ready = 1'b1;
        rt_valid = 1'b0;
        rt_data  = 8'h00;

        // Reset state, with a valid word offered to show ready_o is held low.
        #2;
        check("reset_valid", 64'(vout), 64'h0);
        check("reset_data", 64'(dout), 64'h0);
        check("reset_ready", 64'(rdy_out), 64'h0);
        next_cycle;
        check("reset_hold_ready", 64'(rdy_out), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        vin = 1'b0;
        next_cycle;

        // Basic decodes, back-to-back, ready_i high.
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                vin = 1'b1;
                din = g_basic[c];
            end else begin
                vin = 1'b0;
            end
            @(negedge clk);
            if (c < 4) check("basic_ready", 64'(rdy_out), 64'h1);
            if (c < 2) begin
                check("basic_latency", 64'(vout), 64'h0);
            end else begin
                check("basic_valid", 64'(vout), 64'h1);
                check("basic_data", 64'(dout), 64'(b_basic[c-2]));
            end
            next_cycle;
        end
        @(negedge clk);
        check("basic_drained", 64'(vout), 64'h0);
        next_cycle;

        // Back-pressure: ready_i low for cycles 3..6 of the stream.
        idx_in       = 0;
        idx_out      = 0;
        stalled_prev = 1'b0;
        last_d       = 8'h00;
        for (int c = 0; c < 16; c++) begin
            rdy_in = !(c >= 3 && c <= 6);
            vin    = (idx_in < 6);
            din    = (idx_in < 6) ? g_bp[idx_in] : 8'h00;
            @(negedge clk);
            if (stalled_prev) begin
                check("bp_hold_valid", 64'(vout), 64'h1);
                check("bp_hold_data", 64'(dout), 64'(last_d));
            end
            if (!rdy_in) check("bp_ready_low", 64'(rdy_out), 64'h0);
            if (c == 3) check("bp_occupancy", 64'(idx_in - idx_out), 64'd2);
            fire_in  = vin && rdy_out;
            fire_out = vout && rdy_in;
            if (fire_out) begin
                if (idx_out < 6) check("bp_data", 64'(dout), 64'(b_bp[idx_out]));
                else check("bp_extra_word", 64'(vout), 64'h0);
                idx_out++;
            end
            if (fire_in) idx_in++;
            stalled_prev = vout && !rdy_in;
            last_d       = dout;
            next_cycle;
        end
        check("bp_words_in", 64'(idx_in), 64'd6);
        check("bp_words_out", 64'(idx_out), 64'd6);
        rdy_in = 1'b1;
        vin    = 1'b0;

        // Enable gating: in-flight word drains while input is blocked.
        en  = 3'b100;
        vin = 1'b1;
        din = 8'h03;
        @(negedge clk);
        check("en_ready_on", 64'(rdy_out), 64'h1);
        next_cycle;
        en  = 3'b101;
        din = 8'hC0;
        @(negedge clk);
        check("en_blocked", 64'(rdy_out), 64'h0);
        next_cycle;
        @(negedge clk);
        check("en_blocked2", 64'(rdy_out), 64'h0);
        check("en_drain_valid", 64'(vout), 64'h1);
        check("en_drain_data", 64'(dout), 64'h02);
        next_cycle;
        en = 3'b100;
        @(negedge clk);
        check("en_resume", 64'(rdy_out), 64'h1);
        check("en_no_extra", 64'(vout), 64'h0);
        next_cycle;
        vin = 1'b0;
        @(negedge clk);
        check("en_latency", 64'(vout), 64'h0);
        next_cycle;
        @(negedge clk);
        check("en_word_valid", 64'(vout), 64'h1);
        check("en_word_data", 64'(dout), 64'h80);
        next_cycle;

        // Asynchronous reset with two words in flight.
        vin = 1'b1;
        din = 8'h03;
        next_cycle;
        din = 8'hC0;
        next_cycle;
        vin = 1'b0;
        check("rst_inflight", 64'(vout), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(vout), 64'h0);
        check("rst_async_data", 64'(dout), 64'h0);
        check("rst_async_ready", 64'(rdy_out), 64'h0);
        next_cycle;
        @(negedge clk);
        rst = 1'b0;
        next_cycle;
        vin = 1'b1;
        din = 8'h03;
        @(negedge clk);
        check("rst_no_stale0", 64'(vout), 64'h0);
        next_cycle;
        vin = 1'b0;
        @(negedge clk);
        check("rst_no_stale1", 64'(vout), 64'h0);
        next_cycle;
        @(negedge clk);
        check("rst_new_valid", 64'(vout), 64'h1);
        check("rst_new_data", 64'(dout), 64'h02);
        next_cycle;
        @(negedge clk);
        check("rst_new_single", 64'(vout), 64'h0);
        next_cycle;

        // Round trip of every 8-bit value through three pipeline depths.
        for (int m = 0; m < 256 + 9; m++) begin
            if (m < 256) begin
                rt_valid = 1'b1;
                rt_data  = 8'(m ^ (m >> 1));
            end else begin
                rt_valid = 1'b0;
            end
            @(negedge clk);
            if (m < 256) check("ref_fn", gray_to_bin(64'(rt_data), 8), 64'(m));
            for (int i = 0; i < 3; i++) begin
                s     = rt_stages[i];
                exp_v = (m >= s) && (m - s < 256);
                if (m < 256) check($sformatf("rt_ready_s%0d", s), 64'(rt_ro[i]), 64'h1);
                check($sformatf("rt_valid_s%0d", s), 64'(rt_vo[i]), 64'(exp_v));
                if (exp_v) check($sformatf("rt_data_s%0d", s), 64'(rt_do[i]), 64'(m - s));
            end
            next_cycle;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
